// File: rtl/fpu_dispatch_pkg.sv
// Shared FPU definitions: op encodings, dispatcher state, destination-file and latency helpers.
package fpu_dispatch_pkg;

    localparam logic [3:0] FPUOP_FADD   = 4'b0000;
    localparam logic [3:0] FPUOP_FSUB   = 4'b0001;
    localparam logic [3:0] FPUOP_FMUL   = 4'b0010;
    localparam logic [3:0] FPUOP_FDIV   = 4'b0011;
    localparam logic [3:0] FPUOP_FSQRT  = 4'b0100;
    localparam logic [3:0] FPUOP_FSGNJ  = 4'b0101;
    localparam logic [3:0] FPUOP_FSGNJN = 4'b0110;
    localparam logic [3:0] FPUOP_FSGNJX = 4'b0111;
    localparam logic [3:0] FPUOP_FEQ    = 4'b1000;
    localparam logic [3:0] FPUOP_FLE    = 4'b1001;
    localparam logic [3:0] FPUOP_FLT    = 4'b1010;
    localparam logic [3:0] FPUOP_FCVTWS = 4'b1011;
    localparam logic [3:0] FPUOP_FCVTSW = 4'b1100;
    localparam logic [3:0] FPUOP_IDLE   = 4'b1111;

    localparam logic [31:0] FP_QNAN = 32'h7fc0_0000;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_t;

    function automatic logic is_int_dst(input logic [3:0] op);
        return (op == FPUOP_FEQ) || (op == FPUOP_FLE) || (op == FPUOP_FLT) ||
               (op == FPUOP_FCVTWS);
    endfunction

    // Cycles between fpu_op presentation and fpu_fin; undefined codes complete at once.
    function automatic int unsigned fpu_latency(input logic [3:0] op);
        case (op)
            FPUOP_FADD, FPUOP_FSUB:   return 3;
            FPUOP_FMUL, FPUOP_FCVTSW: return 2;
            FPUOP_FDIV:               return 11;
            FPUOP_FSQRT:              return 7;
            FPUOP_FCVTWS:             return 1;
            default:                  return 0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_dispatch_watchdog.sv
// EXEC-phase cycle counter; flags the cycle in which the op has spent TIMEOUT_CYCLES in EXEC.
module fpu_dispatch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_active,
    output logic o_expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_active) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_active && (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_dispatch.sv
// Single-op FPU requester: accepts from decode, drives the fpu until fin, offers result to writeback.
// Optional timeout abort enabled by defining FPU_DISPATCH_TIMEOUT_EN.
module fpu_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src0,
    input  logic [31:0] req_src1,
    input  logic [4:0]  req_rd,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_src0,
    output logic [31:0] fpu_src1,
    input  logic [31:0] fpu_result,
    input  logic        fpu_fin,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_int,
    output logic        err
);

    state_t      r_state;
    logic [3:0]  r_op;
    logic [31:0] r_src0;
    logic [31:0] r_src1;
    logic [4:0]  r_rd;
    logic        r_int;
    logic [31:0] r_data;
    logic        r_err;

    logic w_accept;
    logic w_timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FPU_DISPATCH_TIMEOUT_EN
    fpu_dispatch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_active  (r_state == StExec),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    assign req_ready = (r_state == StIdle) || ((r_state == StWb) && wb_ready);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_op    <= FPUOP_IDLE;
            r_src0  <= '0;
            r_src1  <= '0;
            r_rd    <= '0;
            r_int   <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_state <= StExec;
                r_op    <= req_op;
                r_src0  <= req_src0;
                r_src1  <= req_src1;
                r_rd    <= req_rd;
                r_int   <= is_int_dst(req_op);
            end else begin
                unique case (r_state)
                    StIdle: r_state <= StIdle;
                    StExec: begin
                        // A result arriving in the timeout cycle takes priority over the abort.
                        if (fpu_fin) begin
                            r_data  <= fpu_result;
                            r_op    <= FPUOP_IDLE;
                            r_state <= StWb;
                        end else if (w_timeout) begin
                            r_data  <= FP_QNAN;
                            r_op    <= FPUOP_IDLE;
                            r_err   <= 1'b1;
                            r_state <= StWb;
                        end
                    end
                    StWb: begin
                        if (wb_ready) begin
                            r_state <= StIdle;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign fpu_op   = r_op;
    assign fpu_src0 = r_src0;
    assign fpu_src1 = r_src1;
    assign wb_valid = (r_state == StWb);
    assign wb_data  = r_data;
    assign wb_rd    = r_rd;
    assign wb_int   = r_int;
    assign err      = r_err;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch paired with a behavioural fpu; directed vectors plus randomized scoreboard.
module tb_fpu_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_src0;
    logic [31:0] req_src1;
    logic [4:0]  req_rd;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_src0;
    logic [31:0] fpu_src1;
    logic [31:0] fpu_result;
    logic        fpu_fin;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_int;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpu_dispatch #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src0   (req_src0),
        .req_src1   (req_src1),
        .req_rd     (req_rd),
        .fpu_op     (fpu_op),
        .fpu_src0   (fpu_src0),
        .fpu_src1   (fpu_src1),
        .fpu_result (fpu_result),
        .fpu_fin    (fpu_fin),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_int     (wb_int),
        .err        (err)
    );

    // ---------------- behavioural fpu ----------------
    function automatic int op_lat(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: return 3;
            4'd2:       return 2;
            4'd3:       return 11;
            4'd4:       return 7;
            4'd11:      return 1;
            4'd12:      return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic real s2r(input logic [31:0] a);
        logic [63:0] d;
        logic [10:0] e;
        if (a[30:0] == 31'd0) return 0.0;
        e = {3'b000, a[30:23]} + 11'd896;
        d = {a[31], e, a[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:0] == 63'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hff, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_calc(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:  return r2s(s2r(a) + s2r(b));
            4'd1:  return r2s(s2r(a) - s2r(b));
            4'd2:  return r2s(s2r(a) * s2r(b));
            4'd3:  return r2s(s2r(a) / s2r(b));
            4'd4:  return a[31] ? 32'h7fc00000 : r2s($sqrt(s2r(a)));
            4'd5:  return {b[31], a[30:0]};
            4'd6:  return {~b[31], a[30:0]};
            4'd7:  return {a[31] ^ b[31], a[30:0]};
            4'd8:  return {31'd0, s2r(a) == s2r(b)};
            4'd9:  return {31'd0, s2r(a) <= s2r(b)};
            4'd10: return {31'd0, s2r(a) < s2r(b)};
            4'd11: return $rtoi(s2r(a));
            4'd12: return r2s($itor($signed(a)));
            default: return 32'd0;
        endcase
    endfunction

    logic [3:0] fcnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          fcnt <= 4'd0;
        else if (fpu_fin) fcnt <= 4'd0;
        else              fcnt <= fcnt + 4'd1;
    end
    always_comb begin
        fpu_fin    = (fpu_op == 4'hf) || (int'(fcnt) == op_lat(fpu_op));
        fpu_result = fpu_fin ? fp_calc(fpu_op, fpu_src0, fpu_src1) : 32'hdead_beef;
    end

`ifdef FPU_DISPATCH_TIMEOUT_EN
    logic        t_req_valid, t_req_ready, t_wb_valid, t_wb_ready, t_wb_int, t_err;
    logic [3:0]  t_fpu_op;
    logic [31:0] t_fpu_src0, t_fpu_src1, t_wb_data;
    logic [4:0]  t_wb_rd;

    fpu_dispatch #(
        .TIMEOUT_CYCLES (4)
    ) dut_to (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (t_req_valid),
        .req_ready  (t_req_ready),
        .req_op     (4'd0),
        .req_src0   (32'h3f800000),
        .req_src1   (32'h40000000),
        .req_rd     (5'd7),
        .fpu_op     (t_fpu_op),
        .fpu_src0   (t_fpu_src0),
        .fpu_src1   (t_fpu_src1),
        .fpu_result (32'd0),
        .fpu_fin    (1'b0),
        .wb_valid   (t_wb_valid),
        .wb_ready   (t_wb_ready),
        .wb_data    (t_wb_data),
        .wb_rd      (t_wb_rd),
        .wb_int     (t_wb_int),
        .err        (t_err)
    );
`endif

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic        exp_int;
        int          lat;
        int          stall;
    } vec_t;

    vec_t vt[$];

    task automatic run_vec(input vec_t v);
        int t;
        bit seen;
        logic [31:0] held;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = v.op;
        req_src0 = v.a;
        req_src1 = v.b;
        req_rd = v.rd;
        wb_ready = 1'b0;
        #1 chk({v.name, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk({v.name, "_fpu_op"}, {28'd0, fpu_op}, {28'd0, v.op});
        chk({v.name, "_fpu_src0"}, fpu_src0, v.a);
        t = 1;
        seen = 0;
        while (t < 40 && !seen) begin
            if (wb_valid) seen = 1;
            else begin
                @(negedge clk);
                #1 t++;
            end
        end
        chk({v.name, "_latency"}, t, 2 + v.lat);
        chk({v.name, "_wb_data"}, wb_data, v.exp);
        chk({v.name, "_wb_int"}, {31'd0, wb_int}, {31'd0, v.exp_int});
        chk({v.name, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
        chk({v.name, "_fpu_op_idle"}, {28'd0, fpu_op}, 32'hf);
        held = wb_data;
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            #1 chk({v.name, "_stall_valid"}, {31'd0, wb_valid}, 32'd1);
            chk({v.name, "_stall_data"}, wb_data, held);
            chk({v.name, "_stall_ready"}, {31'd0, req_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        #1 chk({v.name, "_wb_ready_pass"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        wb_ready = 1'b0;
        #1 chk({v.name, "_back_idle"}, {31'd0, wb_valid}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'(120 + $urandom_range(0, 15));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        bit          have_req, have_pend, e_wbv, e_rdy;
        logic [3:0]  q_op, p_op;
        logic [31:0] q_a, q_b, p_a, p_b;
        logic [4:0]  q_rd, p_rd;
        int          p_t, p_due, t, errs;

        req_op = 4'd0;
        req_src0 = 32'd0;
        req_src1 = 32'd0;
        req_rd = 5'd0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
        t_req_valid = 1'b0;
        t_wb_ready = 1'b0;
`endif
        rst = 1'b1;
        req_valid = 1'b0;
        wb_ready = 1'b0;
        #12;
        chk("reset_fpu_op", {28'd0, fpu_op}, 32'hf);
        chk("reset_src0", fpu_src0, 32'd0);
        chk("reset_src1", fpu_src1, 32'd0);
        chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("reset_wb_int", {31'd0, wb_int}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        do_reset();

        vt.push_back('{"fsgnj",  4'd5,  32'h3f800000, 32'hc0000000, 5'd1,  32'hbf800000, 1'b0, 0, 0});
        vt.push_back('{"fadd",   4'd0,  32'h3f800000, 32'h40000000, 5'd2,  32'h40400000, 1'b0, 3, 0});
        vt.push_back('{"fdiv",   4'd3,  32'h40c00000, 32'h40400000, 5'd3,  32'h40000000, 1'b0, 11, 3});
        vt.push_back('{"feq",    4'd8,  32'h40000000, 32'h40000000, 5'd4,  32'h00000001, 1'b1, 0, 0});
        vt.push_back('{"fmul",   4'd2,  32'h40000000, 32'h40400000, 5'd5,  32'h40c00000, 1'b0, 2, 0});
        vt.push_back('{"fsub",   4'd1,  32'h40400000, 32'h3f800000, 5'd6,  32'h40000000, 1'b0, 3, 0});
        vt.push_back('{"fsqrt",  4'd4,  32'h40800000, 32'h00000000, 5'd7,  32'h40000000, 1'b0, 7, 0});
        vt.push_back('{"fsgnjn", 4'd6,  32'h3f800000, 32'hc0000000, 5'd8,  32'h3f800000, 1'b0, 0, 0});
        vt.push_back('{"fsgnjx", 4'd7,  32'h3f800000, 32'hc0000000, 5'd9,  32'hbf800000, 1'b0, 0, 1});
        vt.push_back('{"flt",    4'd10, 32'h3f800000, 32'h40000000, 5'd10, 32'h00000001, 1'b1, 0, 0});
        vt.push_back('{"fle",    4'd9,  32'h40000000, 32'h3f800000, 5'd11, 32'h00000000, 1'b1, 0, 0});
        vt.push_back('{"fcvtws", 4'd11, 32'h40400000, 32'h00000000, 5'd12, 32'h00000003, 1'b1, 1, 0});
        vt.push_back('{"fcvtsw", 4'd12, 32'h00000005, 32'h00000000, 5'd13, 32'h40a00000, 1'b0, 2, 0});
        vt.push_back('{"op1101", 4'd13, 32'h3f800000, 32'h3f800000, 5'd14, 32'h00000000, 1'b0, 0, 0});
        vt.push_back('{"op1111", 4'd15, 32'h3f800000, 32'h3f800000, 5'd31, 32'h00000000, 1'b0, 0, 2});
        foreach (vt[i]) run_vec(vt[i]);

        // Back-to-back: feq then fmul accepted straight out of WB.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd8; req_src0 = 32'h40000000; req_src1 = 32'h40000000;
        req_rd = 5'd20; wb_ready = 1'b1;
        @(negedge clk);
        req_op = 4'd2; req_src0 = 32'h40000000; req_src1 = 32'h40400000; req_rd = 5'd21;
        @(negedge clk);
        #1 chk("b2b_feq_valid", {31'd0, wb_valid}, 32'd1);
        chk("b2b_feq_data", wb_data, 32'h00000001);
        chk("b2b_feq_int", {31'd0, wb_int}, 32'd1);
        chk("b2b_feq_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("b2b_fmul_op", {28'd0, fpu_op}, 32'h2);
        chk("b2b_gap_valid", {31'd0, wb_valid}, 32'd0);
        repeat (3) @(negedge clk);
        #1 chk("b2b_fmul_valid", {31'd0, wb_valid}, 32'd1);
        chk("b2b_fmul_data", wb_data, 32'h40c00000);
        chk("b2b_fmul_int", {31'd0, wb_int}, 32'd0);
        chk("b2b_fmul_rd", {27'd0, wb_rd}, 32'd21);
        @(negedge clk);
        wb_ready = 1'b0;

        // Asynchronous reset in the middle of an fdiv.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd3; req_src0 = 32'h40c00000; req_src1 = 32'h40400000;
        req_rd = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 chk("rst_pre_op", {28'd0, fpu_op}, 32'h3);
        #1 rst = 1'b1;
        #1 chk("rst_mid_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_mid_op", {28'd0, fpu_op}, 32'hf);
        @(negedge clk);
        rst = 1'b0;
        wb_ready = 1'b1;
        #1 chk("rst_after_ready", {31'd0, req_ready}, 32'd1);
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1 if (wb_valid) errs++;
        end
        chk("rst_no_stale_wb", errs, 0);

`ifdef FPU_DISPATCH_TIMEOUT_EN
        // Watchdog abort with an fpu that never finishes.
        @(negedge clk);
        t_req_valid = 1'b1;
        t_wb_ready = 1'b0;
        @(negedge clk);
        t_req_valid = 1'b0;
        t = 1; errs = 0; p_t = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (t_err) begin
                errs++;
                chk("to_err_with_wb", {31'd0, t_wb_valid}, 32'd1);
            end
            if (t_wb_valid && p_t == 0) begin
                p_t = t;
                chk("to_wb_data", t_wb_data, 32'h7fc00000);
                chk("to_wb_rd", {27'd0, t_wb_rd}, 32'd7);
                chk("to_fpu_op", {28'd0, t_fpu_op}, 32'hf);
            end
            @(negedge clk);
            t++;
        end
        chk("to_err_pulses", errs, 1);
        chk("to_wb_cycle", p_t, 5);
        t_wb_ready = 1'b1;
        @(negedge clk);
        #1 chk("to_back_idle", {31'd0, t_wb_valid}, 32'd0);
        chk("to_idle_ready", {31'd0, t_req_ready}, 32'd1);
`endif

        // Randomized traffic against a transaction-level timing model.
        do_reset();
        have_req = 0;
        have_pend = 0;
        p_op = 4'hf; p_a = 0; p_b = 0; p_rd = 0; p_t = 0; p_due = 0;
        q_op = 4'h0; q_a = 0; q_b = 0; q_rd = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!have_req && $urandom_range(0, 2) != 0) begin
                q_op = 4'($urandom_range(0, 15));
                q_a = (q_op == 4'd12) ? $urandom : rnd_fp();
                q_b = rnd_fp();
                q_rd = 5'($urandom);
                have_req = 1;
            end
            req_valid = have_req;
            req_op = q_op; req_src0 = q_a; req_src1 = q_b; req_rd = q_rd;
            wb_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_wbv = have_pend && (i >= p_due);
            e_rdy = !have_pend || (e_wbv && wb_ready);
            chk("rnd_wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
            chk("rnd_req_ready", {31'd0, req_ready}, {31'd0, e_rdy});
            chk("rnd_err", {31'd0, err}, 32'd0);
            if (e_wbv) begin
                chk("rnd_wb_data", wb_data, fp_calc(p_op, p_a, p_b));
                chk("rnd_wb_rd", {27'd0, wb_rd}, {27'd0, p_rd});
                chk("rnd_wb_int", {31'd0, wb_int},
                    {31'd0, (p_op == 4'd8) || (p_op == 4'd9) || (p_op == 4'd10) || (p_op == 4'd11)});
            end
            if (have_pend && i > p_t && i < p_due) begin
                chk("rnd_fpu_op", {28'd0, fpu_op}, {28'd0, p_op});
                chk("rnd_fpu_src1", fpu_src1, p_b);
            end else begin
                chk("rnd_fpu_op_idle", {28'd0, fpu_op}, 32'hf);
            end
            if (e_wbv && wb_ready) have_pend = 0;
            if (have_req && e_rdy) begin
                have_pend = 1;
                p_op = q_op; p_a = q_a; p_b = q_b; p_rd = q_rd;
                p_t = i;
                p_due = i + 2 + op_lat(q_op);
                have_req = 0;
            end
        end
        req_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (20) @(negedge clk);
        #1 chk("rnd_drained", {31'd0, wb_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
